// File: rtl/riscv_icache_ctrl.sv
// Lookup/refill controller for a direct-mapped instruction cache with dual-index misaligned fetch support.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module riscv_icache_ctrl #(
   parameter int AWIDTH      = 64,
   parameter int INDEX       = 12,
   parameter int BYTE_OFFSET = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [AWIDTH-1:0] cpu_addr,
   input  logic              flush,
   output logic              stall,
   output logic              mem_req,
   output logic [AWIDTH-1:0] mem_addr,
   input  logic              mem_ready,
   output logic              cache_wren,
   output logic              cache_index_sel,
   output logic [INDEX-1:0]  cache_index,
   output logic [INDEX-1:0]  cache_index_missallign,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int TAG   = AWIDTH - INDEX - BYTE_OFFSET;
   localparam int BLKW  = AWIDTH - BYTE_OFFSET;
   localparam int DEPTH = 2 ** INDEX;

   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] REFILL_MAIN = 2'd1;
   localparam logic [1:0] REFILL_NEXT = 2'd2;
   localparam logic [1:0] SETTLE      = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             flush_pending;
   logic [DEPTH-1:0] valid;
   logic [TAG-1:0]   tags [DEPTH];

   logic [BLKW-1:0]  blk;
   logic [BLKW-1:0]  blk_next;
   logic [TAG-1:0]   tag;
   logic [TAG-1:0]   tag_next;
   logic [INDEX-1:0] idx;
   logic [INDEX-1:0] idx_next;
   logic [INDEX-1:0] wr_idx;
   logic             misaligned;
   logic             hit_main;
   logic             hit_next;
   logic             hit;
   logic             lookup;
   logic             refill;

   // The following block shares the tag/index split; its tag carries when the index wraps.
   assign blk        = cpu_addr[AWIDTH-1:BYTE_OFFSET];
   assign blk_next   = blk + {{(BLKW-1){1'b0}}, 1'b1};
   assign {tag, idx}           = blk;
   assign {tag_next, idx_next} = blk_next;
   assign misaligned = cpu_addr[BYTE_OFFSET-1:0] > BYTE_OFFSET'(32'd12);

   assign hit_main = valid[idx] && (tags[idx] == tag);
   assign hit_next = valid[idx_next] && (tags[idx_next] == tag_next);
   assign hit      = hit_main && (!misaligned || hit_next);

   assign lookup = (state == IDLE) && !flush_pending && cpu_req;
   assign refill = (state == REFILL_MAIN) || (state == REFILL_NEXT);

   assign stall                  = rst && ((state != IDLE) || flush_pending || (cpu_req && !hit));
   assign mem_req                = refill;
   assign mem_addr               = {((state == REFILL_NEXT) ? blk_next : blk), {BYTE_OFFSET{1'b0}}};
   assign cache_index_sel        = (state == REFILL_NEXT);
   assign cache_wren             = refill && mem_ready;
   assign cache_index            = idx;
   assign cache_index_missallign = idx_next;
   assign wr_idx                 = cache_index_sel ? idx_next : idx;

   // Next-state selection for the lookup/refill sequence
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (lookup && !hit_main) begin
               state_nxt = REFILL_MAIN;
            end else if (lookup && misaligned && !hit_next) begin
               state_nxt = REFILL_NEXT;
            end else begin
               state_nxt = IDLE;
            end
         end
         REFILL_MAIN: begin
            if (mem_ready) begin
               state_nxt = (misaligned && !hit_next) ? REFILL_NEXT : SETTLE;
            end else begin
               state_nxt = REFILL_MAIN;
            end
         end
         REFILL_NEXT: begin
            if (mem_ready) begin
               state_nxt = SETTLE;
            end else begin
               state_nxt = REFILL_NEXT;
            end
         end
         SETTLE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and deferred-flush latch (a flush seen mid-refill is applied on return to IDLE)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         flush_pending <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            flush_pending <= 1'b0;
         end else if (flush) begin
            flush_pending <= 1'b1;
         end else begin
            flush_pending <= flush_pending;
         end
      end
   end

   // Valid bits: cleared by flush in IDLE, set by each completed block refill
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
      end else if ((state == IDLE) && (flush || flush_pending)) begin
         valid <= '0;
      end else if (cache_wren) begin
         valid[wr_idx] <= 1'b1;
      end else begin
         valid <= valid;
      end
   end

   // Tag store; contents are meaningless until the matching valid bit is set
   always_ff @(posedge clk) begin
      if (cache_wren) begin
         tags[wr_idx] <= cache_index_sel ? tag_next : tag;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hits;
   logic [31:0] misses;

   // Saturating hit/miss statistics
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hits   <= 32'd0;
         misses <= 32'd0;
      end else begin
         if (lookup && hit && (hits != 32'hFFFF_FFFF)) begin
            hits <= hits + 32'd1;
         end else begin
            hits <= hits;
         end
         if (lookup && !hit && (misses != 32'hFFFF_FFFF)) begin
            misses <= misses + 32'd1;
         end else begin
            misses <= misses;
         end
      end
   end

   assign hit_count  = hits;
   assign miss_count = misses;
`else
   assign hit_count  = 32'd0;
   assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_icache_ctrl.sv
// Randomized bench for riscv_icache_ctrl against a block-level cache model.
// Expected statistics follow ICACHE_STATS_EN in the same way as the design.
module tb_riscv_icache_ctrl;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic [63:0] cpu_addr;
   logic        flush;
   logic        stall;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ready;
   logic        cache_wren;
   logic        cache_index_sel;
   logic [11:0] cache_index;
   logic [11:0] cache_index_missallign;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int errors = 0;
   int checks = 0;

   // Model: which 16-byte block number currently lives at each index
   logic        mv [4096];
   logic [59:0] mb [4096];
   bit          pend;
   logic [31:0] exp_hits;
   logic [31:0] exp_misses;

   riscv_icache_ctrl dut (
      .clk                    (clk),
      .rst                    (rst),
      .cpu_req                (cpu_req),
      .cpu_addr               (cpu_addr),
      .flush                  (flush),
      .stall                  (stall),
      .mem_req                (mem_req),
      .mem_addr               (mem_addr),
      .mem_ready              (mem_ready),
      .cache_wren             (cache_wren),
      .cache_index_sel        (cache_index_sel),
      .cache_index            (cache_index),
      .cache_index_missallign (cache_index_missallign),
      .hit_count              (hit_count),
      .miss_count             (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef ICACHE_STATS_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   function automatic bit present(input logic [59:0] b);
      return mv[b % 4096] && (mb[b % 4096] == b);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4096; i++) mv[i] = 1'b0;
   endtask

   task automatic check_stats(input string tag);
      check_eq({tag, "_hits"}, 64'(hit_count), 64'(stat_exp(exp_hits)));
      check_eq({tag, "_misses"}, 64'(miss_count), 64'(stat_exp(exp_misses)));
   endtask

   // One fetch held until it hits; flush_mid pulses flush in the first refill cycle
   task automatic do_fetch(input logic [63:0] a, input bit flush_mid);
      logic [59:0] blk;
      logic [59:0] nblk;
      logic [59:0] need[$];
      bit          mis;
      bit          fl;
      bit          done;
      int          lat;
      fl   = flush_mid;
      done = 1'b0;
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = a;
      blk  = a[63:4];
      nblk = blk + 60'd1;
      mis  = (a[3:0] > 4'd12);
      #1;
      check_stats("stats");
      for (int round = 0; round < 6; round++) begin
         if (round != 0) #1;
         check_eq("cache_index", 64'(cache_index), 64'(blk[11:0]));
         check_eq("index_missallign", 64'(cache_index_missallign), 64'(nblk[11:0]));
         if (pend) begin
            check_eq("stall_flush_pending", 64'(stall), 64'd1);
            check_eq("mem_req_flush_pending", 64'(mem_req), 64'd0);
            model_clear();
            pend = 1'b0;
            @(negedge clk);
            continue;
         end
         need.delete();
         if (!present(blk)) need.push_back(blk);
         if (mis && !present(nblk)) need.push_back(nblk);
         check_eq("stall_lookup", 64'(stall), 64'(need.size() != 0));
         if (need.size() == 0) begin
            exp_hits = exp_hits + 32'd1;
            done = 1'b1;
            break;
         end
         exp_misses = exp_misses + 32'd1;
         foreach (need[k]) begin
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
               @(negedge clk);
               mem_ready = 1'b0;
               flush     = 1'b0;
               if (fl) begin
                  flush = 1'b1;
                  fl    = 1'b0;
                  pend  = 1'b1;
               end
               #1;
               check_eq("mem_req_refill", 64'(mem_req), 64'd1);
               check_eq("mem_addr", mem_addr, {need[k], 4'h0});
               check_eq("index_sel", 64'(cache_index_sel), 64'(need[k] == nblk));
               check_eq("stall_refill", 64'(stall), 64'd1);
               if (c == lat) begin
                  mem_ready = 1'b1;
                  #1;
                  check_eq("wren_ready", 64'(cache_wren), 64'd1);
               end else begin
                  check_eq("wren_wait", 64'(cache_wren), 64'd0);
               end
            end
            mv[need[k] % 4096] = 1'b1;
            mb[need[k] % 4096] = need[k];
         end
         @(negedge clk);
         mem_ready = 1'b0;
         flush     = 1'b0;
         #1;
         check_eq("stall_settle", 64'(stall), 64'd1);
         check_eq("mem_req_settle", 64'(mem_req), 64'd0);
         check_eq("wren_settle", 64'(cache_wren), 64'd0);
         @(negedge clk);
      end
      check_eq("fetch_done", 64'(done), 64'd1);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      cpu_req  = 1'b0;
      cpu_addr = 64'($urandom);
      #1;
      check_eq("stall_noreq", 64'(stall), 64'd0);
      check_eq("mem_req_noreq", 64'(mem_req), 64'd0);
   endtask

   task automatic idle_flush();
      @(negedge clk);
      cpu_req = 1'b0;
      flush   = 1'b1;
      #1;
      check_eq("stall_idle_flush", 64'(stall), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      model_clear();
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] t;
      logic [63:0] ix;
      logic [63:0] off;
      t   = 64'($urandom_range(0, 2));
      off = 64'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
         0:       ix = 64'h000;
         1:       ix = 64'h001;
         2:       ix = 64'h100;
         3:       ix = 64'hFFF;
         default: ix = 64'($urandom_range(0, 3));
      endcase
      return (t << 16) | (ix << 4) | off;
   endfunction

   initial begin
      rst        = 1'b0;
      cpu_req    = 1'b0;
      cpu_addr   = 64'd0;
      flush      = 1'b0;
      mem_ready  = 1'b0;
      pend       = 1'b0;
      exp_hits   = 32'd0;
      exp_misses = 32'd0;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_stall", 64'(stall), 64'd0);
      check_eq("rst_mem_req", 64'(mem_req), 64'd0);
      check_eq("rst_wren", 64'(cache_wren), 64'd0);
      check_eq("rst_index_sel", 64'(cache_index_sel), 64'd0);
      check_stats("rst");
      @(negedge clk);
      rst = 1'b1;

      do_fetch(64'h1000, 1'b0);
      do_fetch(64'h1004, 1'b0);
      do_fetch(64'h201E, 1'b0);
      do_fetch(64'h5FFFE, 1'b0);
      do_fetch(64'h3000, 1'b1);
      do_fetch(64'h1000, 1'b0);

      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 9))
            0:       idle_flush();
            1:       idle_cycle();
            default: do_fetch(rand_addr(), ($urandom_range(0, 7) == 0));
         endcase
      end

      // Reset in the middle of a refill
      idle_flush();
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = 64'h1000;
      #1;
      check_eq("stall_before_rst", 64'(stall), 64'd1);
      @(negedge clk);
      #1;
      check_eq("mem_req_before_rst", 64'(mem_req), 64'd1);
      rst = 1'b0;
      #1;
      check_eq("rst_mid_mem_req", 64'(mem_req), 64'd0);
      check_eq("rst_mid_stall", 64'(stall), 64'd0);
      check_eq("rst_mid_wren", 64'(cache_wren), 64'd0);
      check_eq("rst_mid_hits", 64'(hit_count), 64'd0);
      check_eq("rst_mid_misses", 64'(miss_count), 64'd0);
      model_clear();
      exp_hits   = 32'd0;
      exp_misses = 32'd0;
      @(negedge clk);
      rst = 1'b1;
      do_fetch(64'h1000, 1'b0);
      do_fetch(64'h100C, 1'b0);

      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      check_stats("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_icache_ctrl.md
Name: riscv_icache_ctrl

Overview:
Refill/lookup controller for the direct-mapped instruction cache data array (16-byte blocks, dual-index read for misaligned fetches). Holds the tag/valid store, checks hits for both the addressed block and the following block, and stalls the fetch stage on a miss. Fetches missing blocks from the memory-side port and sequences the data array write strobe, index select and both read indices. Sits between the fetch stage, the data array and the instruction memory interface.

Parameters:
AWIDTH, 64, fetch address width
INDEX, 12, index bits (CACHE_DEPTH = 2**INDEX)
BYTE_OFFSET, 4, block offset bits (16-byte block)
TAG, AWIDTH-INDEX-BYTE_OFFSET, tag width (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-low reset
cpu_req  in  1  fetch request valid
cpu_addr  in  AWIDTH  fetch byte address; held stable while stall=1
flush  in  1  one-cycle pulse (fence.i): invalidate all lines
stall  out  1  fetch must hold; instruction not yet valid
mem_req  out  1  block read request to memory
mem_addr  out  AWIDTH  block-aligned read address (low BYTE_OFFSET bits zero)
mem_ready  in  1  one-cycle pulse: requested block is on the memory data bus
cache_wren  out  1  data array write strobe
cache_index_sel  out  1  0 = write at index, 1 = write at index_missallign
cache_index  out  INDEX  cpu_addr[BYTE_OFFSET+INDEX-1:BYTE_OFFSET]
cache_index_missallign  out  INDEX  cache_index+1, wraps from all-ones to 0
hit_count  out  32  hit counter (optional feature)
miss_count  out  32  miss counter (optional feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all valid bits=0, stall=0, mem_req=0, cache_wren=0, cache_index_sel=0, counters=0. A reset during a refill abandons it: no write strobe, no tag update.
- Tag/valid store: one TAG-wide tag and one valid bit per index, flops. Combinational read.
- misaligned = cpu_addr[BYTE_OFFSET-1:0] > 12 (32-bit instruction crosses the block boundary).
- next-block address = block address + 16. Tag for the next block is tag+1 when the index wraps to 0, otherwise tag.
- hit_main = valid[index] && tag match. hit_next = valid[index+1] && next-block tag match.
- hit = hit_main && (!misaligned || hit_next).
- stall = cpu_req && !hit in IDLE (combinational, same cycle). stall=1 in every non-IDLE state.
- State machine:
  - IDLE:
    - cpu_req && !hit_main -> REFILL_MAIN.
    - cpu_req && hit_main && misaligned && !hit_next -> REFILL_NEXT.
    - Otherwise stay in IDLE.
  - REFILL_MAIN:
    - mem_req=1, mem_addr = block address, cache_index_sel=0.
    - On mem_ready: cache_wren=1 for that cycle, tag[index] and valid[index] are written at posedge.
    - Then go to REFILL_NEXT if misaligned && !hit_next, else to SETTLE.
  - REFILL_NEXT:
    - mem_req=1, mem_addr = next-block address, cache_index_sel=1.
    - On mem_ready: cache_wren=1, tag/valid written at index+1, then go to SETTLE.
  - SETTLE:
    - One cycle with stall=1 so the negedge-registered array outputs reflect the new data.
    - Go to IDLE; the re-evaluated lookup then hits.
- mem_req stays high until mem_ready. mem_addr is stable while mem_req=1. mem_ready is ignored outside the REFILL states.
- cache_wren is high only in a REFILL state on a mem_ready cycle.
- Flush in IDLE: all valid bits are cleared at the next posedge. The lookup in that same cycle uses the pre-flush valids.
- Flush in any other state: latched as pending. The current refill completes (valid still set), then all valids are cleared on the first IDLE cycle. Lookup is suppressed (stall=1) for that cycle.
- cpu_req=0 in IDLE: no lookup, stall=0.

Optional Feature:
ICACHE_STATS_EN:
- Defined: hit_count increments on each IDLE cycle with cpu_req && hit. miss_count increments on each IDLE-to-REFILL transition. Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then cpu_req at addr 0x1000 -> stall=1 same cycle, mem_req=1 with mem_addr=0x1000. mem_ready after 3 cycles -> cache_wren=1, index_sel=0, cache_index=0x100; one SETTLE cycle; then stall=0.
- Second fetch at 0x1004 after the refill -> stall=0 in the request cycle, no mem_req.
- Misaligned fetch at 0x201E, both blocks cold -> mem_addr 0x2010 (index_sel=0), then mem_addr 0x2020 (index_sel=1, index_missallign=0x202), then SETTLE, then hit.
- Misaligned fetch at index 0xFFF, offset 0xE -> cache_index_missallign=0x000 and second mem_addr = block address + 16 (tag+1).
- Flush pulse during REFILL_MAIN -> refill completes. The following IDLE cycle clears all valids, and refetching 0x1000 misses again.
- rst low while mem_req=1 -> mem_req=0, stall=0 immediately. Refetching the same address misses; with ICACHE_STATS_EN defined, counters read 0 after reset.
